// File: rtl/io_stream_write_array_pkg.sv
// Shared types and helpers for the array-to-stream drain stage.
package io_stream_write_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 3;

  // A read may be issued only if its data is guaranteed a FIFO slot on return.
  function automatic logic has_credit(input logic [1:0] occupancy, input logic in_flight);
    return ({1'b0, occupancy} + {2'b00, in_flight}) < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/io_stream_write_array_fifo3.sv
// Three-entry shift FIFO whose head is always entry 0, so the stream output is a plain register.
module stream_fifo3
  import io_stream_write_array_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic [1:0]   occupancy
);

  logic [W-1:0] r_data [FIFO_DEPTH];
  logic [1:0]   r_count;

  logic [W-1:0] w_next [FIFO_DEPTH];
  logic [1:0]   w_base;
  logic [1:0]   w_count_next;
  logic         w_pop;
  logic         w_push_ok;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_next    = r_data;
    w_base    = r_count;
    w_pop     = pop && (r_count != 2'd0);
    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) w_next[i] = r_data[i+1];
      w_next[FIFO_DEPTH-1] = '0;
      w_base = r_count - 2'd1;
    end
    w_push_ok = push && (w_base < 2'(FIFO_DEPTH));
    if (w_push_ok) w_next[w_base] = push_data;
    w_count_next = w_base + {1'b0, w_push_ok};
  end

  // NOTE: the storage is reset too, because the head register drives sOut and must read 0 out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_data[i] <= '0;
      r_count <= 2'd0;
    end else begin
      r_data  <= w_next;
      r_count <= w_count_next;
    end
  end

  assign head       = r_data[0];
  assign head_valid = (r_count != 2'd0);
  assign occupancy  = r_count;

endmodule

// File: rtl/io_stream_write_array.sv
// Reads array elements 0..len-1 and emits them in order on a valid/ready stream, then signals completion.
module io_stream_write_array
  import io_stream_write_array_pkg::*;
#(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_N:0]   len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_N-1:0] arr_addr,
  output logic              arr_we,
  output logic [INT_N-1:0]  arr_di,
  input  logic [INT_N-1:0]  arr_do,
  output logic              arr_valid,
  input  logic              arr_ready,
  output logic [INT_N-1:0]  sOut,
  output logic              sOut_valid,
  input  logic              sOut_ready
);

  localparam logic [ADDR_N:0] CNT_ONE = {{ADDR_N{1'b0}}, 1'b1};

  state_e          r_state;
  logic [ADDR_N:0] r_len;
  logic [ADDR_N:0] r_issued;
  logic [ADDR_N:0] r_emitted;
  logic            r_in_flight;

  logic [1:0]      w_occupancy;
  logic            w_arr_fire;
  logic            w_pop;

  assign arr_valid  = (r_state == ST_RUN) && (r_issued < r_len) && has_credit(w_occupancy, r_in_flight);
  assign w_arr_fire = arr_valid && arr_ready;
  assign w_pop      = sOut_valid && sOut_ready;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign arr_addr  = r_issued[ADDR_N-1:0];
  assign arr_we    = 1'b0;
  assign arr_di    = '0;

  // The read response lands one cycle after acceptance; r_in_flight marks that cycle.
  stream_fifo3 #(.W(INT_N)) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push       (r_in_flight),
    .push_data  (arr_do),
    .pop        (w_pop),
    .head       (sOut),
    .head_valid (sOut_valid),
    .occupancy  (w_occupancy)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_emitted   <= '0;
      r_in_flight <= 1'b0;
    end else begin
      r_in_flight <= w_arr_fire;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_len     <= len;
            r_issued  <= '0;
            r_emitted <= '0;
            r_state   <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_arr_fire) r_issued <= r_issued + CNT_ONE;
          if (w_pop) begin
            r_emitted <= r_emitted + CNT_ONE;
            if ((r_emitted + CNT_ONE) == r_len) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_stream_write_array.sv
// Self-checking bench: table-driven runs, random runs and hand-written reset/stall sequences.
module tb_io_stream_write_array;

  localparam int INT_N  = 8;
  localparam int ADDR_N = 8;
  localparam int DEPTH  = 2 ** ADDR_N;

  logic              clk = 1'b0;
  logic              nrst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_N:0]   len;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic [INT_N-1:0]  arr_do;
  logic              arr_valid;
  logic              arr_ready;
  logic [INT_N-1:0]  sOut;
  logic              sOut_valid;
  logic              sOut_ready;

  io_stream_write_array #(.INT_N(INT_N), .ADDR_N(ADDR_N)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .len        (len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .arr_addr   (arr_addr),
    .arr_we     (arr_we),
    .arr_di     (arr_di),
    .arr_do     (arr_do),
    .arr_valid  (arr_valid),
    .arr_ready  (arr_ready),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Array model: read data appears the cycle after an accepted request.
  logic [INT_N-1:0] mem [DEPTH];
  always @(posedge clk) if (arr_valid && arr_ready) arr_do <= mem[arr_addr];

  // Observer: sampled mid-cycle, when inputs and outputs are both settled.
  logic [INT_N-1:0] got_q [$];
  int               outstanding = 0;
  int               run_acc     = 0;
  int               last_addr   = -1;
  logic             prev_stall  = 1'b0;
  logic [INT_N-1:0] prev_sout   = '0;

  always @(negedge clk) begin
    if (!nrst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("sOut_hold", sOut, prev_sout);
        check("sOut_valid_hold", sOut_valid, 1);
      end
      if (in_valid && in_ready) begin
        run_acc   = 0;
        last_addr = -1;
      end
      if (arr_valid) begin
        check("credit", (outstanding < 3), 1);
        check("arr_addr", arr_addr, run_acc % DEPTH);
      end
      if (arr_valid && arr_ready) begin
        last_addr = arr_addr;
        run_acc++;
        outstanding++;
      end
      if (sOut_valid && sOut_ready) begin
        got_q.push_back(sOut);
        outstanding--;
      end
      prev_stall = sOut_valid && !sOut_ready;
      prev_sout  = sOut;
    end
  end

  typedef struct {
    int len;
    int mem_mode;
    int s_mode;
    int a_mode;
    int exp_cycles;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input int l, input int mm, input int sm, input int am, input int ec);
    vec_t v;
    v.len = l; v.mem_mode = mm; v.s_mode = sm; v.a_mode = am; v.exp_cycles = ec;
    vecs.push_back(v);
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        0:       mem[i] = INT_N'(i);
        1:       mem[i] = INT_N'(DEPTH - 1 - i);
        default: mem[i] = INT_N'($urandom);
      endcase
    end
  endtask

  function automatic logic s_ready_of(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic a_ready_of(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      default: return k >= 5;
    endcase
  endfunction

  task automatic run_one(input int n, input int s_mode, input int a_mode, input int exp_cycles,
                         input string tag);
    int   st;
    int   cyc;
    logic done;
    @(posedge clk); #1;
    st         = got_q.size();
    len        = (ADDR_N + 1)'(n);
    in_valid   = 1'b1;
    sOut_ready = 1'b1;
    arr_ready  = 1'b1;
    done       = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin
        done = 1'b1;
        break;
      end
      if (a_mode == 2 && cyc == 4 && n > 0) begin
        check({tag, ":stall_valid"}, arr_valid, 1);
        check({tag, ":stall_addr"}, arr_addr, 0);
      end
      sOut_ready = s_ready_of(s_mode, cyc);
      arr_ready  = a_ready_of(a_mode, cyc);
    end
    check({tag, ":done"}, done, 1);
    if (exp_cycles >= 0) check({tag, ":cycles"}, cyc, exp_cycles);
    check({tag, ":count"}, got_q.size() - st, n);
    check({tag, ":accepted"}, run_acc, n);
    if (n > 0) check({tag, ":last_addr"}, last_addr, n - 1);
    for (int i = 0; i < n && (st + i) < got_q.size(); i++)
      check({tag, ":data"}, got_q[st+i], mem[i]);
    sOut_ready = 1'b1;
    arr_ready  = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":idle_in_ready"}, in_ready, 1);
    check({tag, ":idle_out_valid"}, out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":in_ready"}, in_ready, 1);
    check({tag, ":out_valid"}, out_valid, 0);
    check({tag, ":arr_valid"}, arr_valid, 0);
    check({tag, ":arr_we"}, arr_we, 0);
    check({tag, ":arr_addr"}, arr_addr, 0);
    check({tag, ":arr_di"}, arr_di, 0);
    check({tag, ":sOut"}, sOut, 0);
    check({tag, ":sOut_valid"}, sOut_valid, 0);
  endtask

  initial begin
    int   st;
    logic got3;
    int   rl;
    int   sm;
    int   am;

    nrst       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    len        = '0;
    sOut_ready = 1'b1;
    arr_ready  = 1'b1;
    arr_do     = '0;
    fill_mem(0);
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    nrst = 1'b1;

    // len, mem_mode, sOut_ready mode, arr_ready mode, expected cycles to out_valid (-1: unchecked)
    add_vec(16,  0, 0, 0, 18);
    add_vec(0,   0, 0, 0, 0);
    add_vec(8,   0, 1, 0, -1);
    add_vec(8,   2, 0, 2, -1);
    add_vec(256, 1, 0, 0, 258);
    add_vec(1,   2, 0, 0, 3);
    add_vec(2,   2, 0, 0, 4);
    add_vec(3,   2, 2, 1, -1);
    add_vec(37,  2, 2, 1, -1);
    add_vec(12,  2, 1, 2, -1);

    foreach (vecs[i]) begin
      fill_mem(vecs[i].mem_mode);
      run_one(vecs[i].len, vecs[i].s_mode, vecs[i].a_mode, vecs[i].exp_cycles,
              $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      rl = $urandom_range(0, 40);
      sm = $urandom_range(0, 2);
      am = $urandom_range(0, 1);
      fill_mem(2);
      run_one(rl, sm, am, (sm == 0 && am == 0) ? ((rl == 0) ? 0 : rl + 2) : -1,
              $sformatf("rand%0d", r));
    end

    // Abort a 10-element run after three pops, then run again from a clean state.
    fill_mem(0);
    @(posedge clk); #1;
    st         = got_q.size();
    len        = (ADDR_N + 1)'(10);
    in_valid   = 1'b1;
    sOut_ready = 1'b1;
    arr_ready  = 1'b1;
    got3       = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (got_q.size() - st >= 3) begin
        got3 = 1'b1;
        break;
      end
    end
    check("rst:reached3", got3, 1);
    check("rst:busy_before", in_ready, 0);
    nrst = 1'b0;
    #1;
    check_reset_outputs("rst_now");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    nrst = 1'b1;
    run_one(4, 0, 0, 6, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_stream_write_array.md
# io_stream_write_array

Drains an `Array` instance into an output stream: on a start handshake it reads elements `0 .. len-1` through the `Array` interface and emits each element, in address order, on a valid/ready stream, then raises a completion handshake. It is the downstream stage of `io_stream_read_array`, which fills the same `array` instance, and together they form the stream-to-array-to-stream path of the I/O fabric. A 3-entry internal FIFO absorbs the array read latency and stream back-pressure, sustaining one element per cycle.

## Interface

Parameters:
- `INT_N`, default `` `intN `` (8): element and stream data width.
- `ADDR_N`, default `` `addrN `` (8): array address width.

Ports:
- `clk`, input, 1: the single clock.
- `nrst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: start request.
- `in_ready`, output, 1: start accepted. High only in IDLE.
- `len`, input, ADDR_N+1: element count, sampled on start. Legal range is 0..2^ADDR_N.
- `out_valid`, output, 1: transfer complete.
- `out_ready`, input, 1: completion acknowledged.
- `arr_addr`, output, ADDR_N: read address.
- `arr_we`, output, 1: always 0.
- `arr_di`, output, INT_N: always 0.
- `arr_do`, input, INT_N: read data, valid in the cycle after request acceptance.
- `arr_valid`, output, 1: read request.
- `arr_ready`, input, 1: array accepts the request.
- `sOut`, output, INT_N: stream data.
- `sOut_valid`, output, 1: stream data valid.
- `sOut_ready`, input, 1: consumer ready.

## Operation

- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - `in_ready` is 1.
  - On `in_valid & in_ready`, latch `len` and clear the issue and emit counters.
  - If `len == 0`, go to DONE; otherwise go to RUN.
- **RUN**
  - Issue reads at addresses 0, 1, … in order.
  - `arr_valid` is 1 when `issued < len` and `occupancy + in_flight < 3`.
  - A request is accepted on `arr_valid & arr_ready`. Advance `arr_addr` on acceptance and set `in_flight` for the next cycle.
  - In the cycle after acceptance, push `arr_do` into the FIFO.
  - Pop the FIFO on `sOut_valid & sOut_ready` and increment `emitted`.
  - Go to DONE on the edge where `emitted` reaches `len`.
- **DONE**
  - `out_valid` is 1.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored.
- Address arithmetic:
  - `arr_addr` is ADDR_N bits. With `len == 2^ADDR_N`, the last address is 2^ADDR_N − 1.
  - The counters are ADDR_N+1 bits, so they never wrap before reaching `len`.
- FIFO:
  - `sOut` and `sOut_valid` come from the FIFO head register, not directly from `arr_do`.
  - Push and pop in the same cycle are allowed, with occupancy unchanged.
  - Overflow is structurally impossible under the credit rule.

## Timing

- Reset values:
  - `in_ready` = 1.
  - `out_valid`, `arr_valid`, `arr_we`, `sOut_valid` = 0.
  - `arr_addr`, `arr_di`, `sOut` = 0.
  - FIFO empty, `in_flight` = 0.
- Latency, with start accepted at edge E0 and `arr_ready` held high:
  - `arr_valid` is high during E0→E1, with address 0 accepted at E1.
  - The data is pushed at E2.
  - `sOut_valid` is high from E2.
- Throughput: with `sOut_ready` and `arr_ready` held high, one element per cycle. N elements finish in N+2 cycles after start. `out_valid` rises on the cycle after the last pop.
- Stream hold: while `sOut_valid & !sOut_ready`, `sOut` stays stable and `sOut_valid` stays high.
- Read hold: while `arr_valid & !arr_ready`, `arr_addr` stays stable.
- Reset mid-operation: returns to IDLE immediately. The FIFO is flushed, and any in-flight read response is discarded.

## Structure

- `` `intT ``, `` `addrT `` and the `` `true ``/`` `reset `` macros stay in the shared `primitives.v`. Both `io_stream_read_array` and this block use them.
- State encodings are local parameters.
- One sub-module, `stream_fifo3`: a 3-entry, INT_N-wide FIFO with a registered head, push/pop, occupancy output and async active-low clear. It is reusable by other stream stages.

## Test plan

- **Basic:** preload the array with `mem[i] = i` and start with `len = 16`, all readies high. Require `sOut` = 0..15 on 16 consecutive cycles, then `out_valid`.
- **Empty:** start with `len = 0`. Require no `arr_valid` and no `sOut_valid`, `out_valid` on the cycle after start, and a return to IDLE when `out_ready` is pulsed.
- **Stream back-pressure:** `len = 8`, `sOut_ready` toggling as 1,0,0,1,… Require the output sequence unchanged, `sOut` stable while stalled, and `arr_valid` never asserted with `occupancy + in_flight = 3`.
- **Array stall:** `arr_ready` low for 5 cycles after the first request. Require `arr_addr` to hold at 0, then the full sequence to be correct.
- **Full range:** `len = 256` with `mem[i] = 255 - i`. Require the last address to be 255, the last `sOut` to be 0, and no address wrap.
- **Reset mid-run:** assert `nrst` low after 3 elements of 10 have been emitted. Require all outputs at reset values immediately, then a new `len = 4` run producing 0..3 correctly.
